spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- Serial front end that drives the single-port RAM: deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) and serialises RAM read data (tx_data/tx_valid) back out on MISO.
- SPI signals (SS_n, MOSI) are synchronous to clk: one bit per clk while SS_n low.
- Sits directly upstream of the RAM; its rx_data[9:8] is the RAM opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).

Parameters:
- ADDR_W, 8, payload width; frame width FRAME_W = ADDR_W+2.
- DATA_W, 8, width of tx_data shifted out on MISO.

Ports:
- clk  in  1  system/SPI clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low; frame framing.
- MOSI  in  1  serial in, MSB first.
- MISO  out  1  serial out, MSB first.
- rx_data  out  FRAME_W  assembled command word to RAM din.
- rx_valid  out  1  one-cycle strobe: rx_data is valid.
- tx_data  in  DATA_W  read data from RAM dout.
- tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift reg=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; else stay.
- CHK_CMD: SS_n=1 -> IDLE. MOSI=0 -> WRITE. MOSI=1 with rd_addr_seen=0 -> READ_ADD. MOSI=1 with rd_addr_seen=1 -> READ_DATA.
- The CHK_CMD bit is not stored. The following FRAME_W bits (bit9..bit0) shift into shreg, one per clk; bit9 repeats the command bit.
- On the cycle the FRAME_W-th bit is sampled: next edge rx_data <= {shreg[FRAME_W-2:0],MOSI}, rx_valid=1 for exactly one cycle.
- After a full frame, further MOSI bits are ignored until SS_n=1.
- READ_ADD completing a frame sets rd_addr_seen=1. READ_DATA completing its 8-bit MISO shift clears rd_addr_seen.
- READ_DATA, after rx_valid: wait indefinitely for tx_valid=1 while SS_n=0. On tx_valid, latch tx_data. Starting the next cycle, drive MISO with tx_data[DATA_W-1] down to [0], one bit per clk. After the last bit, MISO returns to 0.
- tx_valid outside the READ_DATA wait phase is ignored.
- SS_n=1 in any state: next cycle IDLE, counter cleared, MISO=0, no rx_valid. A partial frame is discarded and rd_addr_seen is unchanged.
- SS_n=1 on the same edge the last bit is sampled: frame discarded (abort wins).
- MISO=0 whenever not actively shifting.
- Counter width is clog2(FRAME_W+1) and saturates; it never wraps.

Optional Feature:
- Macro SPI_ABORT_ERR_EN.
- With the macro defined: extra output abort_err (1 bit, reset 0) pulses for one cycle when SS_n rises with a partial frame in progress (0 < bits < FRAME_W), or during READ_DATA before the MISO shift completes.
- Without the macro: port absent, aborts are silent. All other behaviour is identical.

Decomposition:
- Package spi_pkg: state enum type spi_state_e, opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11, FRAME_W localparam.
- One natural sub-module: spi_tx_shifter (load on tx_valid, 8-bit MSB-first shift, done flag). The FSM and RX shift stay in the top.

Test Plan:
- Write address: SS_n=0, MOSI 0 then 00_1010_0101 -> rx_valid pulse with rx_data=10'h0A5, MISO stays 0, state IDLE after SS_n=1.
- Write data: frame 01_0011_1100 -> rx_data=10'h13C, one rx_valid pulse, rd_addr_seen stays 0.
- Read address then read data: frame 10_0000_0111 -> rx_data=10'h207, rd_addr_seen=1. Next frame starts with cmd 1 -> READ_DATA, 11_xxxx_xxxx -> rx_valid.
  - Bench returns tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on the following 8 clks. rd_addr_seen=0 afterwards.
- Abort: SS_n rises after 5 bits of a WRITE frame -> no rx_valid, IDLE next cycle. abort_err pulses if SPI_ABORT_ERR_EN.
  - A subsequent full frame 00_1111_1111 -> rx_data=10'h0FF.
- Async reset mid READ_DATA shift (after 3 MISO bits): MISO=0, rx_valid=0, state IDLE immediately, rd_addr_seen=0. The next read frame goes to READ_ADD.
- No tx_valid: READ_DATA frame with tx_valid held 0 for 20 clks -> MISO stays 0, no hang after SS_n=1 (IDLE next cycle).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end feeding the single-port RAM.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first MISO serialiser: load latches a word, then one bit per clk, then MISO idles at 0.
module spi_tx_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done_c
);

    localparam int unsigned CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     rem;
    logic              active;

    // High while the final bit is on MISO; the shift completes on the next edge.
    assign done_c = active && (rem == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg   <= '0;
            rem    <= '0;
            active <= 1'b0;
            miso   <= 1'b0;
        end else if (clear) begin
            sreg   <= '0;
            rem    <= '0;
            active <= 1'b0;
            miso   <= 1'b0;
        end else if (load) begin
            miso   <= data[DATA_W-1];
            sreg   <= {data[DATA_W-2:0], 1'b0};
            rem    <= CW'(DATA_W - 1);
            active <= 1'b1;
        end else if (active) begin
            if (rem == '0) begin
                active <= 1'b0;
                miso   <= 1'b0;
            end else begin
                miso <= sreg[DATA_W-1];
                sreg <= {sreg[DATA_W-2:0], 1'b0};
                rem  <= rem - CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: MOSI frames -> RAM command words, RAM read data -> MISO.
// Optional abort_err output enabled by defining SPI_ABORT_ERR_EN.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_ABORT_ERR_EN
    ,
    output logic              abort_err
`endif
);

    localparam int unsigned FRAME_LEN = ADDR_W + 2;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    spi_state_e             state;
    logic [CNT_W-1:0]       cnt;
    logic [FRAME_LEN-2:0]   shreg;
    logic                   rd_addr_seen;
    logic                   tx_started;
    logic                   load_c;
    logic                   done_c;
`ifdef SPI_ABORT_ERR_EN
    logic                   rd_done;
`endif

    // Read data is accepted only once per READ_DATA frame, after the frame is complete.
    assign load_c = (state == READ_DATA) && !SS_n && tx_valid && !tx_started
                    && (cnt == CNT_W'(FRAME_LEN));

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_c),
        .clear  (SS_n),
        .data   (tx_data),
        .miso   (MISO),
        .done_c (done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_started   <= 1'b0;
`ifdef SPI_ABORT_ERR_EN
            rd_done      <= 1'b0;
            abort_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_ABORT_ERR_EN
            abort_err <= 1'b0;
`endif
            if (SS_n) begin
                // Deselect wins over everything, including a frame's final bit.
                state      <= IDLE;
                cnt        <= '0;
                tx_started <= 1'b0;
`ifdef SPI_ABORT_ERR_EN
                rd_done    <= 1'b0;
                abort_err  <= ((state == WRITE || state == READ_ADD)
                               && cnt != '0 && cnt != CNT_W'(FRAME_LEN))
                              || (state == READ_DATA && !rd_done);
`endif
            end else begin
                case (state)
                    IDLE:    state <= CHK_CMD;
                    CHK_CMD: state <= !MOSI ? WRITE : (rd_addr_seen ? READ_DATA : READ_ADD);
                    default: begin
                        if (cnt != CNT_W'(FRAME_LEN)) begin
                            shreg <= {shreg[FRAME_LEN-3:0], MOSI};
                            cnt   <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                                rx_data  <= {shreg, MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                            end
                        end
                        if (load_c) tx_started <= 1'b1;
                        if (done_c) begin
                            rd_addr_seen <= 1'b0;
`ifdef SPI_ABORT_ERR_EN
                            rd_done      <= 1'b1;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if (abort_err checked when SPI_ABORT_ERR_EN is defined).
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_ABORT_ERR_EN
    logic       abort_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave_if #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_ABORT_ERR_EN
        ,
        .abort_err(abort_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select, send the command bit, then nbits of the frame MSB first; record rx_valid and MISO activity.
    task automatic send_frame(input logic cmd, input logic [9:0] bits, input int nbits,
                              output int pulses, output logic [9:0] last, output logic miso_seen);
        logic [9:0] b;
        b = bits;
        pulses = 0;
        last = '0;
        miso_seen = 1'b0;
        SS_n = 1'b0;
        tick();
        MOSI = cmd;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[9];
            b = {b[8:0], 1'b0};
            tick();
            if (rx_valid) begin
                pulses++;
                last = rx_data;
            end
            miso_seen = miso_seen | MISO;
        end
    endtask

    task automatic deselect();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick(); tick();
        n_checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got miso=%b rx_valid=%b rx_data=%h, need 0 0 000", MISO, rx_valid, rx_data);
        end
        n_checks++;
        if (dut.state !== IDLE || dut.rd_addr_seen !== 1'b0 || dut.cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d rd_addr_seen=%b cnt=%0d, need 0 0 0", dut.state, dut.rd_addr_seen, dut.cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_addr();
        int p; logic [9:0] d; logic m;
        send_frame(1'b0, {OP_WR_ADDR, 8'hA5}, 10, p, d, m);
        n_checks++;
        if (p !== 1 || d !== 10'h0A5) begin
            n_fail++;
            $display("FAIL wr_addr_frame: got pulses=%0d rx_data=%h, need 1 0a5", p, d);
        end
        n_checks++;
        if (m !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_addr_miso: got miso activity=%b, need 0", m);
        end
        MOSI = 1'b1;
        tick();
        n_checks++;
        if (rx_valid !== 1'b0 || dut.cnt !== 4'd10) begin
            n_fail++;
            $display("FAIL wr_addr_extra_bits: got rx_valid=%b cnt=%0d, need 0 10", rx_valid, dut.cnt);
        end
        deselect();
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL wr_addr_idle: got state=%0d, need %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_write_data();
        int p; logic [9:0] d; logic m;
        send_frame(1'b0, {OP_WR_DATA, 8'h3C}, 10, p, d, m);
        n_checks++;
        if (p !== 1 || d !== 10'h13C || dut.rd_addr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_data_frame: got pulses=%0d rx_data=%h rd_addr_seen=%b, need 1 13c 0", p, d, dut.rd_addr_seen);
        end
        deselect();
    endtask

    task automatic test_read();
        int p; logic [9:0] d; logic m;
        logic [7:0] exp_bits;
        logic       miso_ok;
        send_frame(1'b1, {OP_RD_ADDR, 8'h07}, 10, p, d, m);
        n_checks++;
        if (p !== 1 || d !== 10'h207 || dut.rd_addr_seen !== 1'b1 || dut.state !== READ_ADD) begin
            n_fail++;
            $display("FAIL rd_addr_frame: got pulses=%0d rx_data=%h seen=%b state=%0d, need 1 207 1 %0d", p, d, dut.rd_addr_seen, dut.state, READ_ADD);
        end
        deselect();
        n_checks++;
        if (dut.rd_addr_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_addr_seen_kept: got %b, need 1", dut.rd_addr_seen);
        end
        send_frame(1'b1, {OP_RD_DATA, 8'hC5}, 10, p, d, m);
        n_checks++;
        if (p !== 1 || d !== 10'h3C5 || dut.state !== READ_DATA || MISO !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data_frame: got pulses=%0d rx_data=%h state=%0d miso=%b, need 1 3c5 %0d 0", p, d, dut.state, MISO, READ_DATA);
        end
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        exp_bits = 8'b1100_0011;
        miso_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (MISO !== exp_bits[7]) miso_ok = 1'b0;
            exp_bits = {exp_bits[6:0], 1'b0};
            tick();
        end
        n_checks++;
        if (miso_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_data_miso: got serial mismatch on MISO, need 1,1,0,0,0,0,1,1");
        end
        n_checks++;
        if (MISO !== 1'b0 || dut.rd_addr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data_done: got miso=%b seen=%b, need 0 0", MISO, dut.rd_addr_seen);
        end
        // A late tx_valid must not restart the shift.
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick(); tick();
        tx_valid = 1'b0;
        n_checks++;
        if (MISO !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data_late_tx_valid: got miso=%b, need 0", MISO);
        end
        deselect();
    endtask

    task automatic test_abort();
        int p; logic [9:0] d; logic m;
        send_frame(1'b0, 10'h155, 5, p, d, m);
        SS_n = 1'b1;
        tick();
        n_checks++;
        if (p !== 0 || rx_valid !== 1'b0 || dut.state !== IDLE || dut.cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_partial: got pulses=%0d rx_valid=%b state=%0d cnt=%0d, need 0 0 0 0", p, rx_valid, dut.state, dut.cnt);
        end
`ifdef SPI_ABORT_ERR_EN
        n_checks++;
        if (abort_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_err_pulse: got %b, need 1", abort_err);
        end
`endif
        send_frame(1'b0, {OP_WR_ADDR, 8'hFF}, 10, p, d, m);
        n_checks++;
        if (p !== 1 || d !== 10'h0FF) begin
            n_fail++;
            $display("FAIL abort_recover: got pulses=%0d rx_data=%h, need 1 0ff", p, d);
        end
        deselect();
        // Deselect on the same edge as the final bit discards the frame.
        send_frame(1'b0, 10'h2AA, 9, p, d, m);
        MOSI = 1'b0;
        SS_n = 1'b1;
        tick();
        n_checks++;
        if (p !== 0 || rx_valid !== 1'b0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL abort_last_bit: got pulses=%0d rx_valid=%b state=%0d, need 0 0 0", p, rx_valid, dut.state);
        end
`ifdef SPI_ABORT_ERR_EN
        n_checks++;
        if (abort_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_err_last_bit: got %b, need 1", abort_err);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int p; logic [9:0] d; logic m;
        send_frame(1'b1, {OP_RD_ADDR, 8'h11}, 10, p, d, m);
        deselect();
        send_frame(1'b1, {OP_RD_DATA, 8'h22}, 10, p, d, m);
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (MISO !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got miso=%b, need 1", MISO);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || dut.state !== IDLE || dut.rd_addr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_shift: got miso=%b rx_valid=%b state=%0d seen=%b, need 0 0 0 0", MISO, rx_valid, dut.state, dut.rd_addr_seen);
        end
        SS_n = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        SS_n = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        n_checks++;
        if (dut.state !== READ_ADD) begin
            n_fail++;
            $display("FAIL rst_next_read: got state=%0d, need %0d", dut.state, READ_ADD);
        end
        deselect();
    endtask

    task automatic test_no_tx_valid();
        int p; logic [9:0] d; logic m;
        logic miso_any;
        send_frame(1'b1, {OP_RD_ADDR, 8'h33}, 10, p, d, m);
        deselect();
        send_frame(1'b1, {OP_RD_DATA, 8'h44}, 10, p, d, m);
        tx_valid = 1'b0;
        miso_any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            miso_any = miso_any | MISO;
        end
        n_checks++;
        if (miso_any !== 1'b0 || dut.state !== READ_DATA) begin
            n_fail++;
            $display("FAIL no_tx_wait: got miso activity=%b state=%0d, need 0 %0d", miso_any, dut.state, READ_DATA);
        end
        deselect();
        n_checks++;
        if (dut.state !== IDLE || MISO !== 1'b0 || dut.rd_addr_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL no_tx_exit: got state=%0d miso=%b seen=%b, need 0 0 1", dut.state, MISO, dut.rd_addr_seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_reset_mid_shift();
        test_no_tx_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
